// File: rtl/lvds_framer_pkg.sv
// Shared constants, state type and word helpers for the LVDS output framer.
// Raster counters count down; all positions below are in counter units.
package lvds_fmt_pkg;

  localparam logic [10:0] H_ACT_FIRST = 11'd1055;
  localparam logic [10:0] V_ACT_FIRST = 11'd1025;
  localparam logic [10:0] H_MAX       = 11'd1063;
  localparam logic [10:0] V_MAX       = 11'd1027;

  localparam int CODE_LEN = 4;
  localparam int ACT_LEN  = 1024;

  localparam logic [10:0] H_SAV_PT   = H_ACT_FIRST + 11'(CODE_LEN);
  localparam logic [10:0] H_ACT_LAST = H_ACT_FIRST - 11'(ACT_LEN - 1);
  localparam logic [10:0] V_ACT_LAST = V_ACT_FIRST - 11'(ACT_LEN - 1);

  localparam logic [9:0] C_PRE     = 10'h3FF;
  localparam logic [9:0] C_ZERO    = 10'h000;
  localparam logic [9:0] C_SAV_ACT = 10'h200;
  localparam logic [9:0] C_EAV_ACT = 10'h274;
  localparam logic [9:0] C_SAV_BLK = 10'h2AC;
  localparam logic [9:0] C_EAV_BLK = 10'h2D8;
  localparam logic [9:0] C_BLANK   = 10'h040;
  localparam logic [9:0] C_CLIP_LO = 10'h004;
  localparam logic [9:0] C_CLIP_HI = 10'h3FB;

  typedef enum logic [1:0] {ST_IDLE, ST_SAV, ST_ACT, ST_EAV} state_t;

  // Keeps pixel data out of the code-word reserved ranges.
  function automatic logic [9:0] clip(input logic [9:0] p);
    if (p < C_CLIP_LO)      return C_CLIP_LO;
    else if (p > C_CLIP_HI) return C_CLIP_HI;
    else                    return p;
  endfunction

  function automatic logic [9:0] code_word(input logic [1:0] idx, input logic [9:0] xyz);
    case (idx)
      2'd0:    return C_PRE;
      2'd1,
      2'd2:    return C_ZERO;
      default: return xyz;
    endcase
  endfunction

endpackage

// File: rtl/lvds_framer_if.sv
// Raster/pixel input and framed-word output bundle of the LVDS framer.
// master = raster source and word sink; slave = the framer itself.
interface lvds_framer_if;
  logic [10:0] ah;
  logic [10:0] av;
  logic [9:0]  pix;
  logic        en;
  logic [9:0]  dout;
  logic        lval;
  logic        fval;
  logic [15:0] fcnt;
  logic        resync;

  modport master (output ah, av, pix, en, input dout, lval, fval, fcnt, resync);
  modport slave  (input ah, av, pix, en, output dout, lval, fval, fcnt, resync);
endinterface

// File: rtl/lvds_xyz_enc.sv
// Combinational BT.656 XYZ word from F/V/H with protection bits.
// Zero latency; no flow control.
module lvds_xyz_enc (
  input  logic       f,
  input  logic       v,
  input  logic       h,
  output logic [9:0] xyz
);
  assign xyz = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
endmodule

// File: rtl/lvds_framer.sv
// Frames the LVDS pixel stream with SAV/EAV codes, valid strobes and frame counter.
// One-cycle registered latency from each ah/av/pix sample; no backpressure (free-running raster).
module lvds_framer
  import lvds_fmt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  lvds_framer_if.slave  bus
);

  state_t      state, state_n;
  logic [1:0]  wcnt, wcnt_n;
  logic [10:0] ah_prev;
  logic        prev_vld;
  logic        en_l;
  logic [15:0] fcnt_q;
  logic [9:0]  dout_q, dout_n;
  logic        lval_q, lval_n, fval_q, fval_n, resync_q, resync_n;
  logic        line_act, en_eff, disc;
  logic [9:0]  sav_xyz, eav_xyz;

  assign line_act = (bus.av <= V_ACT_FIRST) && (bus.av >= V_ACT_LAST);
  // The line-start sample already sees the enable it is about to latch.
  assign en_eff   = (bus.ah == H_MAX) ? bus.en : en_l;
  assign disc     = prev_vld && (bus.ah != ah_prev - 11'd1) &&
                    !(ah_prev == 11'd0 && bus.ah == H_MAX);

  lvds_xyz_enc u_sav (.f(1'b0), .v(!line_act), .h(1'b0), .xyz(sav_xyz));
  lvds_xyz_enc u_eav (.f(1'b0), .v(!line_act), .h(1'b1), .xyz(eav_xyz));

  always_comb begin
    state_n  = state;
    wcnt_n   = wcnt;
    dout_n   = C_BLANK;
    lval_n   = 1'b0;
    resync_n = disc;
    fval_n   = en_eff && line_act;
    if (disc && state != ST_IDLE) begin
      // Abort: the line gets no EAV; framing restarts at the next SAV point.
      state_n = ST_IDLE;
      wcnt_n  = 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_l && bus.ah == H_SAV_PT && !disc) begin
            dout_n  = code_word(2'd0, sav_xyz);
            wcnt_n  = 2'd1;
            state_n = ST_SAV;
          end
        end
        ST_SAV: begin
          dout_n = code_word(wcnt, sav_xyz);
          wcnt_n = wcnt + 2'd1;
          if (wcnt == 2'd3) state_n = ST_ACT;
        end
        ST_ACT: begin
          if (bus.av == V_MAX && bus.ah == H_ACT_FIRST) begin
            dout_n = {2'b01, fcnt_q[15:8]};
          end else if (bus.av == V_MAX && bus.ah == H_ACT_FIRST - 11'd1) begin
            dout_n = {2'b01, fcnt_q[7:0]};
          end else if (line_act) begin
            dout_n = clip(bus.pix);
            lval_n = 1'b1;
          end
          if (bus.ah == H_ACT_LAST) begin
            state_n = ST_EAV;
            wcnt_n  = 2'd0;
          end
        end
        ST_EAV: begin
          dout_n = code_word(wcnt, eav_xyz);
          wcnt_n = wcnt + 2'd1;
          if (wcnt == 2'd3) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wcnt     <= 2'd0;
      ah_prev  <= 11'd0;
      prev_vld <= 1'b0;
      en_l     <= 1'b0;
      fcnt_q   <= 16'd0;
      dout_q   <= C_BLANK;
      lval_q   <= 1'b0;
      fval_q   <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      ah_prev  <= bus.ah;
      prev_vld <= 1'b1;
      if (bus.ah == H_MAX) en_l <= bus.en;
      if (bus.av == 11'd0 && bus.ah == 11'd0) fcnt_q <= fcnt_q + 16'd1;
      dout_q   <= dout_n;
      lval_q   <= lval_n;
      fval_q   <= fval_n;
      resync_q <= resync_n;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.lval   = lval_q;
  assign bus.fval   = fval_q;
  assign bus.fcnt   = fcnt_q;
  assign bus.resync = resync_q;

endmodule

// File: tb/tb_lvds_framer.sv
// Directed bench for lvds_framer: per-line word tables plus hand sequences
// for discontinuity, enable drop, mid-line reset and frame-counter wrap.
module tb_lvds_framer;

  typedef struct {
    int         ah;
    logic [9:0] dout;
    logic       lval;
  } vec_t;

  logic clk;
  logic rst;
  lvds_framer_if bus();

  lvds_framer dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  logic [9:0] obs_dout   [0:1063];
  logic       obs_lval   [0:1063];
  logic       obs_fval   [0:1063];
  logic       obs_resync [0:1063];

  vec_t blank_v[$];
  vec_t act_v[$];

  int n_lval, n_fval, n_res, n_nonblank, n_pre;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int a, input int v, input logic [9:0] p, input logic e);
    bus.ah  = 11'(a);
    bus.av  = 11'(v);
    bus.pix = p;
    bus.en  = e;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ramp 0..1023 across the active window, 1: constant 0x3FF, 2: zero
  task automatic drive_line(input int v, input int mode, input logic en_v,
                            input int hi, input int lo, input int drop);
    logic [9:0] p;
    logic       e;
    for (int a = hi; a >= lo; a--) begin
      if (mode == 0)      p = (a <= 1055 && a >= 32) ? 10'(1055 - a) : 10'd0;
      else if (mode == 1) p = 10'h3FF;
      else                p = 10'd0;
      e = (drop >= 0 && a <= drop) ? 1'b0 : en_v;
      tick(a, v, p, e);
      obs_dout[a]   = bus.dout;
      obs_lval[a]   = bus.lval;
      obs_fval[a]   = bus.fval;
      obs_resync[a] = bus.resync;
    end
  endtask

  task automatic tally(input int hi, input int lo);
    n_lval = 0; n_fval = 0; n_res = 0; n_nonblank = 0; n_pre = 0;
    for (int a = hi; a >= lo; a--) begin
      if (obs_lval[a])   n_lval++;
      if (obs_fval[a])   n_fval++;
      if (obs_resync[a]) n_res++;
      if (obs_dout[a] != 10'h040) n_nonblank++;
      if (obs_lval[a] && obs_dout[a] == 10'h3FF) n_pre++;
    end
  endtask

  task automatic check_tab(input string tag, input vec_t t[$]);
    foreach (t[i]) begin
      chk($sformatf("%s_dout@%0d", tag, t[i].ah), 32'(obs_dout[t[i].ah]), 32'(t[i].dout));
      chk($sformatf("%s_lval@%0d", tag, t[i].ah), 32'(obs_lval[t[i].ah]), 32'(t[i].lval));
    end
  endtask

  initial begin
    blank_v.push_back('{1060, 10'h040, 1'b0});
    blank_v.push_back('{1059, 10'h3FF, 1'b0});
    blank_v.push_back('{1058, 10'h000, 1'b0});
    blank_v.push_back('{1057, 10'h000, 1'b0});
    blank_v.push_back('{1056, 10'h2AC, 1'b0});
    blank_v.push_back('{1055, 10'h040, 1'b0});
    blank_v.push_back('{1054, 10'h040, 1'b0});
    blank_v.push_back('{500,  10'h040, 1'b0});
    blank_v.push_back('{32,   10'h040, 1'b0});
    blank_v.push_back('{31,   10'h3FF, 1'b0});
    blank_v.push_back('{30,   10'h000, 1'b0});
    blank_v.push_back('{29,   10'h000, 1'b0});
    blank_v.push_back('{28,   10'h2D8, 1'b0});
    blank_v.push_back('{27,   10'h040, 1'b0});

    act_v.push_back('{1060, 10'h040, 1'b0});
    act_v.push_back('{1059, 10'h3FF, 1'b0});
    act_v.push_back('{1058, 10'h000, 1'b0});
    act_v.push_back('{1057, 10'h000, 1'b0});
    act_v.push_back('{1056, 10'h200, 1'b0});
    act_v.push_back('{1055, 10'h004, 1'b1});
    act_v.push_back('{1054, 10'h004, 1'b1});
    act_v.push_back('{1053, 10'h004, 1'b1});
    act_v.push_back('{1052, 10'h004, 1'b1});
    act_v.push_back('{1051, 10'h004, 1'b1});
    act_v.push_back('{1050, 10'h005, 1'b1});
    act_v.push_back('{800,  10'h0FF, 1'b1});
    act_v.push_back('{32,   10'h3FB, 1'b1});
    act_v.push_back('{31,   10'h3FF, 1'b0});
    act_v.push_back('{30,   10'h000, 1'b0});
    act_v.push_back('{29,   10'h000, 1'b0});
    act_v.push_back('{28,   10'h274, 1'b0});
    act_v.push_back('{27,   10'h040, 1'b0});

    // Reset state
    rst = 1'b1;
    bus.ah = 11'd0; bus.av = 11'd0; bus.pix = 10'd0; bus.en = 1'b0;
    #12;
    chk("rst_dout", 32'(bus.dout), 32'h040);
    chk("rst_lval", 32'(bus.lval), 32'h0);
    chk("rst_fval", 32'(bus.fval), 32'h0);
    chk("rst_fcnt", 32'(bus.fcnt), 32'h0);
    chk("rst_resync", 32'(bus.resync), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Blanking line, first line after enable
    drive_line(1026, 2, 1'b1, 1063, 0, -1);
    check_tab("blank", blank_v);
    tally(1063, 0);
    chk("blank_fval_cnt", 32'(n_fval), 32'd0);
    chk("blank_resync_cnt", 32'(n_res), 32'd0);

    // Active line with ramp
    drive_line(1025, 0, 1'b1, 1063, 0, -1);
    check_tab("act", act_v);
    tally(1063, 0);
    chk("act_lval_cnt", 32'(n_lval), 32'd1024);
    chk("act_fval_cnt", 32'(n_fval), 32'd1064);

    // Clipping: saturated pixels
    drive_line(1024, 1, 1'b1, 1063, 0, -1);
    tally(1063, 0);
    chk("clip_first", 32'(obs_dout[1055]), 32'h3FB);
    chk("clip_last", 32'(obs_dout[32]), 32'h3FB);
    chk("clip_no_3ff", 32'(n_pre), 32'd0);
    chk("clip_lval_cnt", 32'(n_lval), 32'd1024);

    // Discontinuity: ah jumps 500 -> 1063
    drive_line(1023, 0, 1'b1, 1063, 500, -1);
    chk("disc_pre_dout", 32'(obs_dout[500]), 32'h22B);
    tally(1063, 500);
    chk("disc_pre_resync", 32'(n_res), 32'd0);
    drive_line(1022, 0, 1'b1, 1063, 0, -1);
    chk("disc_resync", 32'(obs_resync[1063]), 32'h1);
    chk("disc_lval", 32'(obs_lval[1063]), 32'h0);
    chk("disc_dout", 32'(obs_dout[1063]), 32'h040);
    chk("disc_idle_dout", 32'(obs_dout[1062]), 32'h040);
    check_tab("disc_next", act_v);
    tally(1063, 0);
    chk("disc_resync_cnt", 32'(n_res), 32'd1);
    chk("disc_lval_cnt", 32'(n_lval), 32'd1024);

    // Enable dropped mid-line: line completes, next line blank
    drive_line(1021, 0, 1'b1, 1063, 0, 600);
    check_tab("endrop", act_v);
    drive_line(1020, 0, 1'b0, 1063, 0, -1);
    tally(1063, 0);
    chk("endis_nonblank", 32'(n_nonblank), 32'd0);
    chk("endis_lval_cnt", 32'(n_lval), 32'd0);
    chk("endis_fval_cnt", 32'(n_fval), 32'd0);

    // Asynchronous reset mid-line
    drive_line(1019, 0, 1'b1, 1063, 300, -1);
    chk("prerst_dout", 32'(obs_dout[300]), 32'h2F3);
    rst = 1'b1;
    #1;
    chk("midrst_dout", 32'(bus.dout), 32'h040);
    chk("midrst_lval", 32'(bus.lval), 32'h0);
    chk("midrst_fval", 32'(bus.fval), 32'h0);
    chk("midrst_fcnt", 32'(bus.fcnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_line(1019, 0, 1'b1, 299, 0, -1);
    tally(299, 0);
    chk("postrst_nonblank", 32'(n_nonblank), 32'd0);
    chk("postrst_fval_cnt", 32'(n_fval), 32'd0);
    chk("postrst_resync_cnt", 32'(n_res), 32'd0);
    drive_line(1018, 0, 1'b1, 1063, 0, -1);
    check_tab("postrst_line", act_v);

    // Frame counter wrap and header
    for (int i = 0; i < 65535; i++) tick(0, 0, 10'd0, 1'b1);
    chk("fcnt_ffff", 32'(bus.fcnt), 32'hFFFF);
    tick(0, 0, 10'd0, 1'b1);
    chk("fcnt_wrap", 32'(bus.fcnt), 32'h0000);
    drive_line(1027, 2, 1'b1, 1063, 1050, -1);
    chk("hdr0_sav", 32'(obs_dout[1056]), 32'h2AC);
    chk("hdr0_hi", 32'(obs_dout[1055]), 32'h100);
    chk("hdr0_lo", 32'(obs_dout[1054]), 32'h100);
    chk("hdr0_after", 32'(obs_dout[1053]), 32'h040);
    tick(0, 0, 10'd0, 1'b1);
    chk("fcnt_one", 32'(bus.fcnt), 32'h0001);
    drive_line(1027, 2, 1'b1, 1063, 1053, -1);
    chk("hdr1_hi", 32'(obs_dout[1055]), 32'h100);
    chk("hdr1_lo", 32'(obs_dout[1054]), 32'h101);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/lvds_framer.md
# lvds_framer

Output framer for the camera LVDS link. Consumes the free-running LVDS raster counters (`ahlvds`/`avlvds`, both counting down) and the pixel stream aligned to them. Produces a 10-bit word stream with embedded BT.656-style SAV/EAV codes, frame/line valid strobes and a frame-counter header. Sits directly downstream of the sync generator and upstream of the LVDS serializer.

## Interface
- `H_ACT_FIRST`, 1055, `ah` value of first active pixel; the active window is 1024 pixels, 1055..32.
- `V_ACT_FIRST`, 1025, `av` value of first active line; the active window is 1024 lines, 1025..2.
- `H_MAX`, 1063, line reload value of `ah`.
- `V_MAX`, 1027, frame reload value of `av`.
- `clk`  in  1  pixel clock, 65.625 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `ah`  in  11  LVDS horizontal counter: H_MAX down to 0.
- `av`  in  11  LVDS vertical counter: decrements when `ah`==0.
- `pix`  in  10  pixel data, valid on the same cycle as its `ah`/`av`.
- `en`  in  1  framing enable; sampled only at line start (`ah`==H_MAX).
- `dout`  out  10  framed word stream.
- `lval`  out  1  high while `dout` carries an active pixel.
- `fval`  out  1  high for the whole of every active line.
- `fcnt`  out  16  frame counter.
- `resync`  out  1  one-cycle pulse when a counter discontinuity aborts the current line.

## Operation
- **Reset values:** `dout`=0x040, `lval`=0, `fval`=0, `fcnt`=0, `resync`=0; FSM in IDLE; `en_l` (latched enable)=0.
- **Line classification:** the line is active when V_ACT_FIRST >= `av` >= V_ACT_FIRST-1023; otherwise it is a blanking line (V=1).
- **FSM states:** IDLE, SAV, ACT, EAV.
  - IDLE -> SAV when `en_l` is set and `ah`==H_ACT_FIRST+4.
  - SAV emits 4 words at `ah` 1059..1056, then goes to ACT.
  - ACT runs over `ah` 1055..32, then goes to EAV.
  - EAV emits 4 words at `ah` 31..28, then returns to IDLE.
  - A 2-bit word counter sequences SAV and EAV.
- **Code words:** each code is 0x3FF, 0x000, 0x000, XYZ, with F=0.
  - SAV active line = 0x200; EAV active line = 0x274.
  - SAV blanking line = 0x2AC; EAV blanking line = 0x2D8.
  - Codes are sent on every line, active or blanking.
- **ACT data:**
  - On an active line: `dout` = clipped `pix`. Values 0x000..0x003 become 0x004; values 0x3FC..0x3FF become 0x3FB. `lval`=1.
  - On a blanking line: `dout`=0x040, `lval`=0.
  - Exception on line `av`==V_MAX: at `ah`=1055 `dout`={2'b01,fcnt[15:8]}; at `ah`=1054 `dout`={2'b01,fcnt[7:0]}.
- **IDLE:** `dout`=0x040.
- **fval:** 1 from the first cycle of an active line (`ah`==H_MAX) through its `ah`==0; 0 otherwise. Forced to 0 while `en_l`=0.
- **fcnt:** increments on the cycle `av`==0 && `ah`==0 and wraps 0xFFFF -> 0x0000. It counts regardless of `en`.
- **Discontinuity:** `ah` != `ah_prev`-1 and not (`ah_prev`==0 && `ah`==H_MAX).
  - If this happens while in SAV, ACT or EAV: pulse `resync`, go to IDLE, drop `lval`, suppress EAV for that line.
  - Framing resumes at the next valid SAV point.
  - A discontinuity in IDLE pulses `resync` only.
- **Enable:** `en` changes apply only at line start, so a line is never truncated by `en`.

## Timing
- Every output is registered with 1-cycle latency from its `ah`/`av`/`pix` sample.
- `ah_prev` is a registered copy of `ah`.
- Discontinuity detection and the resulting `resync` appear on the same output cycle as the offending sample's word.
- Asynchronous `rst` mid-line: outputs go to their reset values immediately. After release, the first framed output is the next SAV with `en_l` set; `en_l` latches on the next `ah`==H_MAX.
- **Simultaneous events:**
  - `fcnt` increment and `av` reload coincide: the header on line V_MAX shows the new count.
  - Discontinuity and the SAV entry point coincide: the discontinuity wins and the FSM stays in IDLE for that line.

## Structure
- Package `lvds_fmt_pkg`:
  - FSM state enum.
  - Code constants: 0x3FF, 0x000, 0x200, 0x274, 0x2AC, 0x2D8, blank 0x040, clip limits 0x004/0x3FB.
  - SAV/EAV offset (4) and active length (1024).
- One sub-module, `lvds_xyz_enc`: combinational XYZ generator from (F, V, H), with protection bits P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.

## Test plan
- **Reset and enable:** reset, then `en`=1 and counters free-running. Required on a blanking line: `dout` 0x3FF, 000, 000, 2AC at `ah` 1059..1056 (seen one cycle later), 0x040 body, then 3FF, 000, 000, 2D8.
- **Active line:** `av`=1025, `pix`=ramp 0..1023. Required: SAV 0x200; `lval` high for exactly 1024 cycles; first words 0x004, 0x004, 0x004, 0x004, 0x004, 0x005; EAV 0x274; `fval` high 1064 cycles.
- **Clipping:** `pix`=0x3FF throughout the active window. Required: `dout`=0x3FB and no 0x3FF ever appears in ACT.
- **Frame counter:** preload by running 0xFFFF frames, or force-check the wrap. Required: after `av`=0/`ah`=0, `fcnt` goes 0xFFFF -> 0x0000, and the header words at `ah` 1055/1054 on line 1027 read 0x100, 0x100.
- **Discontinuity:** jump `ah` to 1063 at `ah`=500 on an active line. Required: one `resync` pulse, `lval` low next cycle, no EAV on that line, and correct SAV on the following line.
- **Mid-line enable drop and reset:** drop `en` at `ah`=600 and verify the line completes with EAV and the next line is 0x040 only. Then assert `rst` at `ah`=300 and verify immediate reset values.
